// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out receiver with per-frame direction and a
// double-buffered valid/ready output. Optional even-parity check via `PARITY_CHECK_EN.
`default_nettype none

module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Clear_n,
    input  logic             Ser_in,
    input  logic             Ser_valid,
    input  logic             Dir,
    input  logic             Out_ready,
    output logic [0:WIDTH-1] OUT,
    output logic             Out_valid,
    output logic             Busy,
    output logic             Overrun,
    output logic             Parity_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic [0:WIDTH-1] sreg;
    logic [0:WIDTH-1] sh_up;
    logic [0:WIDTH-1] sh_dn;
    logic [0:WIDTH-1] shifted;
    logic [0:WIDTH-1] word;
    logic             last_data;
    logic             complete;
    logic             buf_free;

    always_comb begin
        sh_up    = '0;
        sh_dn    = '0;
        sh_up[0] = Ser_in;
        for (int i = 1; i < WIDTH; i++) begin
            sh_up[i] = sreg[i-1];
        end
        sh_dn[WIDTH-1] = Ser_in;
        for (int i = 0; i < WIDTH - 1; i++) begin
            sh_dn[i] = sreg[i+1];
        end
        // Direction comes live from Dir on the first bit, then from the latched copy.
        shifted   = (((state == IDLE) ? Dir : dir_q) != 1'b0) ? sh_up : sh_dn;
        last_data = Ser_valid && (state != PARITY) && (cnt == CW'(WIDTH - 1));
`ifdef PARITY_CHECK_EN
        complete  = Ser_valid && (state == PARITY);
        word      = sreg;
`else
        complete  = last_data;
        word      = shifted;
`endif
        buf_free  = !Out_valid || Out_ready;
    end

    always_ff @(negedge Clk) begin
        if (!Clear_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_q     <= 1'b0;
            sreg      <= '0;
            OUT       <= '0;
            Out_valid <= 1'b0;
            Overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            Parity_err <= 1'b0;
`endif
        end else begin
            if (Ser_valid) begin
                case (state)
                    IDLE, SHIFT: begin
                        sreg <= shifted;
                        if (state == IDLE) begin
                            dir_q <= Dir;
                        end
                        if (last_data) begin
                            cnt <= '0;
`ifdef PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt   <= cnt + CW'(1);
                            state <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A completing word wins over a plain consume on the same edge.
            if (complete) begin
                if (buf_free) begin
                    OUT       <= word;
                    Out_valid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Out_valid && Out_ready) begin
                Out_valid <= 1'b0;
            end

`ifdef PARITY_CHECK_EN
            if (complete && ((^sreg) ^ Ser_in)) begin
                Parity_err <= 1'b1;
            end
`endif
        end
    end

`ifndef PARITY_CHECK_EN
    assign Parity_err = 1'b0;
`endif

    assign Busy = (state != IDLE);

endmodule

`default_nettype wire
